// File: rtl/ecc_secded_decoder.sv
// Read-side SECDED decoder: 2-stage valid/ready pipeline (syndrome, then classify/correct),
// with saturating CE/UE counters and capture of the first uncorrectable-error tag.
module ecc_secded_decoder #(
   parameter  int DATA_WIDTH   = 8,
   parameter  int ADDR_WIDTH   = 4,
   parameter  int CNT_WIDTH    = 16,
   localparam int PARITY_BITS  = $clog2(DATA_WIDTH) + 1,
   localparam int ENCODED_WORD = DATA_WIDTH + PARITY_BITS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [ENCODED_WORD+1:1] i_word,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [DATA_WIDTH-1:0]   o_data,
   output logic [ADDR_WIDTH-1:0]   o_addr,
   output logic                    o_ce,
   output logic                    o_ue,
   output logic [PARITY_BITS-1:0]  o_syndrome,
   input  logic                    i_clr_cnt,
   output logic [CNT_WIDTH-1:0]    o_ce_cnt,
   output logic [CNT_WIDTH-1:0]    o_ue_cnt,
   output logic [ADDR_WIDTH-1:0]   o_ue_addr,
   output logic                    o_ue_addr_vld
);

   localparam logic [PARITY_BITS-1:0] MAX_POS = PARITY_BITS'(ENCODED_WORD);

   // Positions 1..ENCODED_WORD whose index has bit k set (coverage of parity bit 2^k).
   function automatic logic [ENCODED_WORD:1] cover_mask(input int k);
      logic [ENCODED_WORD:1] m;
      m = '0;
      for (int n = 1; n <= ENCODED_WORD; n++) begin
         m[n] = ((n >> k) & 1) != 0;
      end
      return m;
   endfunction

   // Codeword position of data bit k: the k-th non-power-of-two index.
   function automatic int data_pos(input int k);
      int cnt;
      int pos;
      cnt = 0;
      pos = 0;
      for (int n = 1; n <= ENCODED_WORD; n++) begin
         if ((n & (n - 1)) != 0) begin
            if (cnt == k) pos = n;
            cnt++;
         end
      end
      return pos;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
      return (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
   endfunction

   logic                   v_s1_q;
   logic [DATA_WIDTH-1:0]  raw_s1_q;
   logic [ADDR_WIDTH-1:0]  addr_s1_q;
   logic [PARITY_BITS-1:0] syn_s1_q;
   logic                   par_s1_q;

   logic                   v_s2_q;
   logic [DATA_WIDTH-1:0]  data_s2_q;
   logic [ADDR_WIDTH-1:0]  addr_s2_q;
   logic                   ce_s2_q;
   logic                   ue_s2_q;
   logic [PARITY_BITS-1:0] syn_s2_q;

   logic [CNT_WIDTH-1:0]   ce_cnt_q, ce_cnt_d;
   logic [CNT_WIDTH-1:0]   ue_cnt_q, ue_cnt_d;
   logic [ADDR_WIDTH-1:0]  ue_addr_q, ue_addr_d;
   logic                   ue_addr_vld_q, ue_addr_vld_d;

   logic                   adv_s1, adv_s2, xfer_out;
   logic [PARITY_BITS-1:0] syn_d;
   logic [DATA_WIDTH-1:0]  raw_d;
   logic                   par_d;
   logic                   syn_nz, syn_in_rng, corr_s1;
   logic [DATA_WIDTH-1:0]  data_d;
   logic                   ce_d, ue_d;

   assign adv_s2   = !v_s2_q || i_ready;
   assign adv_s1   = !v_s1_q || adv_s2;
   assign o_ready  = adv_s1;
   assign xfer_out = v_s2_q && i_ready;

   // Stage 1: syndrome, overall parity and raw data extraction
   for (genvar k = 0; k < PARITY_BITS; k++) begin : g_syn
      localparam logic [ENCODED_WORD:1] MASK = cover_mask(k);
      assign syn_d[k] = ^(i_word[ENCODED_WORD:1] & MASK);
   end

   assign par_d = ^i_word;

   assign syn_nz     = |syn_s1_q;
   assign syn_in_rng = syn_s1_q <= MAX_POS;
   assign corr_s1    = syn_nz && par_s1_q && syn_in_rng;

   // Flipping a parity position never touches data, so only data positions need a flip term.
   for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_data
      localparam int POS = data_pos(k);
      assign raw_d[k]  = i_word[POS];
      assign data_d[k] = raw_s1_q[k] ^ (corr_s1 && (syn_s1_q == PARITY_BITS'(POS)));
   end

   assign ce_d = par_s1_q && (!syn_nz || syn_in_rng);
   assign ue_d = syn_nz && (!par_s1_q || !syn_in_rng);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_s1_q    <= 1'b0;
         raw_s1_q  <= '0;
         addr_s1_q <= '0;
         syn_s1_q  <= '0;
         par_s1_q  <= 1'b0;
      end else if (adv_s1) begin
         v_s1_q <= i_valid;
         if (i_valid) begin
            raw_s1_q  <= raw_d;
            addr_s1_q <= i_addr;
            syn_s1_q  <= syn_d;
            par_s1_q  <= par_d;
         end
      end
   end

   // Stage 2: classification and corrected data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_s2_q    <= 1'b0;
         data_s2_q <= '0;
         addr_s2_q <= '0;
         ce_s2_q   <= 1'b0;
         ue_s2_q   <= 1'b0;
         syn_s2_q  <= '0;
      end else if (adv_s2) begin
         v_s2_q <= v_s1_q;
         if (v_s1_q) begin
            data_s2_q <= data_d;
            addr_s2_q <= addr_s1_q;
            ce_s2_q   <= ce_d;
            ue_s2_q   <= ue_d;
            syn_s2_q  <= syn_s1_q;
         end
      end
   end

   assign o_valid    = v_s2_q;
   assign o_data     = data_s2_q;
   assign o_addr     = addr_s2_q;
   assign o_ce       = ce_s2_q;
   assign o_ue       = ue_s2_q;
   assign o_syndrome = syn_s2_q;

   // Statistics: clear has priority over any same-cycle increment or capture
   always_comb begin
      ce_cnt_d      = ce_cnt_q;
      ue_cnt_d      = ue_cnt_q;
      ue_addr_d     = ue_addr_q;
      ue_addr_vld_d = ue_addr_vld_q;
      if (i_clr_cnt) begin
         ce_cnt_d      = '0;
         ue_cnt_d      = '0;
         ue_addr_d     = '0;
         ue_addr_vld_d = 1'b0;
      end else if (xfer_out) begin
         if (ce_s2_q) ce_cnt_d = sat_inc(ce_cnt_q);
         if (ue_s2_q) begin
            ue_cnt_d = sat_inc(ue_cnt_q);
            if (!ue_addr_vld_q) begin
               ue_addr_d     = addr_s2_q;
               ue_addr_vld_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ce_cnt_q      <= '0;
         ue_cnt_q      <= '0;
         ue_addr_q     <= '0;
         ue_addr_vld_q <= 1'b0;
      end else begin
         ce_cnt_q      <= ce_cnt_d;
         ue_cnt_q      <= ue_cnt_d;
         ue_addr_q     <= ue_addr_d;
         ue_addr_vld_q <= ue_addr_vld_d;
      end
   end

   assign o_ce_cnt      = ce_cnt_q;
   assign o_ue_cnt      = ue_cnt_q;
   assign o_ue_addr     = ue_addr_q;
   assign o_ue_addr_vld = ue_addr_vld_q;

endmodule

// File: tb/tb_ecc_secded_decoder.sv
module tb_ecc_secded_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic        i_clr_cnt = 1'b0;
  logic [13:1] i_word = '0;
  logic [3:0]  i_addr = '0;

  logic        o_ready, o_valid, o_ce, o_ue, o_ue_addr_vld;
  logic [7:0]  o_data;
  logic [3:0]  o_addr, o_syndrome, o_ue_addr;
  logic [15:0] o_ce_cnt, o_ue_cnt;

  logic        s_ready, s_valid, s_ce, s_ue, s_ue_addr_vld;
  logic [7:0]  s_data;
  logic [3:0]  s_addr, s_syndrome, s_ue_addr;
  logic [1:0]  s_ce_cnt, s_ue_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ecc_secded_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_word(i_word),
    .i_addr(i_addr), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_addr(o_addr),
    .o_ce(o_ce), .o_ue(o_ue), .o_syndrome(o_syndrome), .i_clr_cnt(i_clr_cnt),
    .o_ce_cnt(o_ce_cnt), .o_ue_cnt(o_ue_cnt), .o_ue_addr(o_ue_addr),
    .o_ue_addr_vld(o_ue_addr_vld)
  );

  ecc_secded_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(s_ready), .i_word(i_word),
    .i_addr(i_addr), .o_valid(s_valid), .i_ready(i_ready), .o_data(s_data), .o_addr(s_addr),
    .o_ce(s_ce), .o_ue(s_ue), .o_syndrome(s_syndrome), .i_clr_cnt(i_clr_cnt),
    .o_ce_cnt(s_ce_cnt), .o_ue_cnt(s_ue_cnt), .o_ue_addr(s_ue_addr),
    .o_ue_addr_vld(s_ue_addr_vld)
  );

  task automatic send(input logic [13:1] w, input logic [3:0] a);
    i_valid = 1'b1;
    i_word  = w;
    i_addr  = a;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_valid, o_ready, o_ue_addr_vld} !== 3'b010) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 010", {o_valid, o_ready, o_ue_addr_vld});
    end
    checks++;
    if ({o_ce_cnt, o_ue_cnt, o_data, o_ue_addr, o_syndrome} !== 48'h0) begin
      errors++;
      $display("FAIL reset_regs got %h exp 0", {o_ce_cnt, o_ue_cnt, o_data, o_ue_addr, o_syndrome});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_release got %b exp 01", {o_valid, o_ready});
    end
  endtask

  task automatic test_clean();
    send(13'h0A27, 4'd3);
    checks++;
    if ({o_valid, o_data, o_addr, o_ce, o_ue, o_syndrome} !== {1'b1, 8'hA5, 4'd3, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL clean_beat got %h exp %h", {o_valid, o_data, o_addr, o_ce, o_ue, o_syndrome},
               {1'b1, 8'hA5, 4'd3, 1'b0, 1'b0, 4'd0});
    end
    @(negedge clk);
    checks++;
    if ({o_valid, o_ce_cnt, o_ue_cnt, o_ue_addr_vld} !== {1'b0, 16'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL clean_counts got %h exp 0", {o_valid, o_ce_cnt, o_ue_cnt, o_ue_addr_vld});
    end
  endtask

  task automatic test_single_error();
    send(13'h0A07, 4'd1);
    checks++;
    if ({o_valid, o_data, o_addr, o_ce, o_ue, o_syndrome} !== {1'b1, 8'hA5, 4'd1, 1'b1, 1'b0, 4'd6}) begin
      errors++;
      $display("FAIL ce_bit6 got %h exp %h", {o_valid, o_data, o_addr, o_ce, o_ue, o_syndrome},
               {1'b1, 8'hA5, 4'd1, 1'b1, 1'b0, 4'd6});
    end
    @(negedge clk);
    checks++;
    if (o_ce_cnt !== 16'd1) begin
      errors++;
      $display("FAIL ce_cnt_1 got %0d exp 1", o_ce_cnt);
    end

    send(13'h1A27, 4'd2);
    checks++;
    if ({o_valid, o_data, o_addr, o_ce, o_ue, o_syndrome} !== {1'b1, 8'hA5, 4'd2, 1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL ce_bit13 got %h exp %h", {o_valid, o_data, o_addr, o_ce, o_ue, o_syndrome},
               {1'b1, 8'hA5, 4'd2, 1'b1, 1'b0, 4'd0});
    end
    @(negedge clk);
    checks++;
    if (o_ce_cnt !== 16'd2) begin
      errors++;
      $display("FAIL ce_cnt_2 got %0d exp 2", o_ce_cnt);
    end

    send(13'h0227, 4'd4);
    checks++;
    if ({o_valid, o_data, o_addr, o_ce, o_ue, o_syndrome} !== {1'b1, 8'hA5, 4'd4, 1'b1, 1'b0, 4'd12}) begin
      errors++;
      $display("FAIL ce_bit12 got %h exp %h", {o_valid, o_data, o_addr, o_ce, o_ue, o_syndrome},
               {1'b1, 8'hA5, 4'd4, 1'b1, 1'b0, 4'd12});
    end
    @(negedge clk);

    send(13'h0AA7, 4'd5);
    checks++;
    if ({o_valid, o_data, o_addr, o_ce, o_ue, o_syndrome} !== {1'b1, 8'hA5, 4'd5, 1'b1, 1'b0, 4'd8}) begin
      errors++;
      $display("FAIL ce_bit8 got %h exp %h", {o_valid, o_data, o_addr, o_ce, o_ue, o_syndrome},
               {1'b1, 8'hA5, 4'd5, 1'b1, 1'b0, 4'd8});
    end
    @(negedge clk);
    checks++;
    if ({o_ce_cnt, o_ue_cnt, s_ce_cnt} !== {16'd4, 16'd0, 2'd3}) begin
      errors++;
      $display("FAIL ce_cnt_4 got %h exp %h", {o_ce_cnt, o_ue_cnt, s_ce_cnt}, {16'd4, 16'd0, 2'd3});
    end
  endtask

  task automatic test_double_error();
    send(13'h0A33, 4'd9);
    checks++;
    if ({o_valid, o_data, o_addr, o_ce, o_ue, o_syndrome} !== {1'b1, 8'hA6, 4'd9, 1'b0, 1'b1, 4'd6}) begin
      errors++;
      $display("FAIL ue_double got %h exp %h", {o_valid, o_data, o_addr, o_ce, o_ue, o_syndrome},
               {1'b1, 8'hA6, 4'd9, 1'b0, 1'b1, 4'd6});
    end
    @(negedge clk);
    checks++;
    if ({o_ue_cnt, o_ue_addr, o_ue_addr_vld, o_ce_cnt} !== {16'd1, 4'd9, 1'b1, 16'd4}) begin
      errors++;
      $display("FAIL ue_capture got %h exp %h", {o_ue_cnt, o_ue_addr, o_ue_addr_vld, o_ce_cnt},
               {16'd1, 4'd9, 1'b1, 16'd4});
    end

    send(13'h0AAE, 4'd2);
    checks++;
    if ({o_valid, o_data, o_addr, o_ce, o_ue, o_syndrome} !== {1'b1, 8'hA5, 4'd2, 1'b0, 1'b1, 4'd13}) begin
      errors++;
      $display("FAIL ue_range got %h exp %h", {o_valid, o_data, o_addr, o_ce, o_ue, o_syndrome},
               {1'b1, 8'hA5, 4'd2, 1'b0, 1'b1, 4'd13});
    end
    @(negedge clk);
    checks++;
    if ({o_ue_cnt, o_ue_addr, o_ue_addr_vld} !== {16'd2, 4'd9, 1'b1}) begin
      errors++;
      $display("FAIL ue_first_kept got %h exp %h", {o_ue_cnt, o_ue_addr, o_ue_addr_vld},
               {16'd2, 4'd9, 1'b1});
    end
  endtask

  task automatic test_clear();
    i_clr_cnt = 1'b1;
    @(negedge clk);
    i_clr_cnt = 1'b0;
    checks++;
    if ({o_ce_cnt, o_ue_cnt, o_ue_addr, o_ue_addr_vld, s_ce_cnt, s_ue_cnt} !== '0) begin
      errors++;
      $display("FAIL clear got %h exp 0",
               {o_ce_cnt, o_ue_cnt, o_ue_addr, o_ue_addr_vld, s_ce_cnt, s_ue_cnt});
    end
  endtask

  task automatic test_back_to_back();
    logic [13:1] vec [6];
    logic        vce [6];
    int          sent;
    int          rcvd;
    vec = '{13'h0A27, 13'h0A07, 13'h0A27, 13'h1A27, 13'h0A27, 13'h0227};
    vce = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 40 && rcvd < 6; cyc++) begin
      i_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 6) begin
        i_valid = 1'b1;
        i_word  = vec[sent];
        i_addr  = 4'(10 + sent);
      end else begin
        i_valid = 1'b0;
      end
      #1;
      checks++;
      if (o_ready !== !((sent - rcvd) == 2 && !i_ready)) begin
        errors++;
        $display("FAIL b2b_ready cyc %0d got %b inflight %0d i_ready %b", cyc, o_ready,
                 sent - rcvd, i_ready);
      end
      if (o_valid && i_ready) begin
        checks++;
        if ({o_data, o_addr, o_ce, o_ue} !== {8'hA5, 4'(10 + rcvd), vce[rcvd], 1'b0}) begin
          errors++;
          $display("FAIL b2b_beat%0d got %h exp %h", rcvd, {o_data, o_addr, o_ce, o_ue},
                   {8'hA5, 4'(10 + rcvd), vce[rcvd], 1'b0});
        end
        rcvd++;
      end
      if (i_valid && o_ready) sent++;
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    checks++;
    if (rcvd != 6) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 6", rcvd);
    end
    checks++;
    if ({o_valid, o_ce_cnt, o_ue_cnt, s_ce_cnt} !== {1'b0, 16'd3, 16'd0, 2'd3}) begin
      errors++;
      $display("FAIL b2b_counts got %h exp %h", {o_valid, o_ce_cnt, o_ue_cnt, s_ce_cnt},
               {1'b0, 16'd3, 16'd0, 2'd3});
    end
  endtask

  task automatic test_saturation();
    send(13'h0A07, 4'd6);
    @(negedge clk);
    checks++;
    if ({o_ce_cnt, s_ce_cnt} !== {16'd4, 2'd3}) begin
      errors++;
      $display("FAIL ce_saturate got %h exp %h", {o_ce_cnt, s_ce_cnt}, {16'd4, 2'd3});
    end
  endtask

  task automatic test_clear_wins();
    i_valid = 1'b1;
    i_word  = 13'h0A33;
    i_addr  = 4'd7;
    @(negedge clk);
    i_valid   = 1'b0;
    i_clr_cnt = 1'b1;
    @(negedge clk);
    i_clr_cnt = 1'b0;
    checks++;
    if ({o_valid, o_data, o_addr, o_ue, o_ce_cnt} !== {1'b1, 8'hA6, 4'd7, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL clr_pipe got %h exp %h", {o_valid, o_data, o_addr, o_ue, o_ce_cnt},
               {1'b1, 8'hA6, 4'd7, 1'b1, 16'd0});
    end
    @(negedge clk);
    checks++;
    if ({o_ue_cnt, o_ue_addr, o_ue_addr_vld} !== {16'd1, 4'd7, 1'b1}) begin
      errors++;
      $display("FAIL clr_recapture got %h exp %h", {o_ue_cnt, o_ue_addr, o_ue_addr_vld},
               {16'd1, 4'd7, 1'b1});
    end

    send(13'h0A07, 4'd8);
    i_clr_cnt = 1'b1;
    @(negedge clk);
    i_clr_cnt = 1'b0;
    checks++;
    if ({o_valid, o_ce_cnt, o_ue_cnt, o_ue_addr_vld, s_ce_cnt} !== {1'b0, 16'd0, 16'd0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL clr_wins got %h exp 0", {o_valid, o_ce_cnt, o_ue_cnt, o_ue_addr_vld, s_ce_cnt});
    end
  endtask

  task automatic test_reset_inflight();
    i_valid = 1'b1;
    i_word  = 13'h0A27;
    i_addr  = 4'd1;
    @(negedge clk);
    i_word  = 13'h0A07;
    i_addr  = 4'd2;
    @(negedge clk);
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL inflight_setup got %b exp 1", o_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rst_async got %b exp 01", {o_valid, o_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_valid, o_ready, o_ce_cnt} !== {1'b0, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL rst_drop got %h exp %h", {o_valid, o_ready, o_ce_cnt}, {1'b0, 1'b1, 16'd0});
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_stale got %b exp 0", o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_double_error();
    test_clear();
    test_back_to_back();
    test_saturation();
    test_clear_wins();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
